// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: issues one word-aligned i-cache request at a time,
// pushes returned words into a DEPTH-word fetch buffer and handles pipeline redirects.
module fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000,
  parameter int          DEPTH    = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         redirect_i,
  input  logic [31:0]                  redirect_pc_i,
  input  logic                         pop_i,
  output logic                         icache_req_o,
  output logic [31:0]                  icache_addr_o,
  input  logic                         icache_ack_i,
  input  logic [31:0]                  icache_instr_i,
  output logic                         buf_push_o,
  output logic [31:0]                  buf_wdata_o,
  output logic [31:0]                  buf_pc_o,
  output logic                         buf_flush_o,
  output logic                         misalign_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] ONE     = CW'(1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef enum logic [1:0] {IDLE, FETCH, FULL, DROP} state_t;

  state_t      state;
  logic [31:0] fetch_addr;
  logic [31:0] addr_inc;
  logic [31:0] redirect_word;
  logic        pop_eff;
  logic        ack_take;
  logic [CW-1:0] count_next;

  assign addr_inc      = fetch_addr + 32'd4;
  assign redirect_word = {redirect_pc_i[31:2], 2'b00};
  assign ack_take      = icache_req_o && icache_ack_i;
  assign pop_eff       = pop_i && (count_o != '0);

  // A response is only buffered when it belongs to the live fetch stream.
  assign buf_push_o  = (state == FETCH) && ack_take && !redirect_i;
  assign buf_wdata_o = buf_push_o ? icache_instr_i : '0;
  assign buf_pc_o    = buf_push_o ? fetch_addr : '0;
  // Gated by reset so the flush pulse cannot leak out while the block is held in reset.
  assign buf_flush_o = reset && redirect_i;

  always_comb begin
    // NOTE: default assignment first so every path drives count_next and no latch is inferred.
    count_next = count_o;
    if (redirect_i) begin
      count_next = '0;
    end else if (buf_push_o && !pop_eff) begin
      count_next = count_o + ONE;
    end else if (!buf_push_o && pop_eff) begin
      count_next = count_o - ONE;
    end
  end

  // NOTE: non-blocking assignments so every register samples the pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      fetch_addr    <= RESET_PC;
      count_o       <= '0;
      misalign_o    <= 1'b0;
      icache_req_o  <= 1'b0;
      icache_addr_o <= '0;
    end else begin
      count_o <= count_next;
      if (redirect_i) begin
        fetch_addr <= redirect_word;
        misalign_o <= redirect_pc_i[1];
        if (((state == FETCH) || (state == DROP)) && !icache_ack_i) begin
          // The old request must still run to its ack; request and address hold.
          state <= DROP;
        end else begin
          state         <= FETCH;
          icache_req_o  <= 1'b1;
          icache_addr_o <= redirect_word;
        end
      end else begin
        case (state)
          IDLE: begin
            state         <= FETCH;
            icache_req_o  <= 1'b1;
            icache_addr_o <= fetch_addr;
          end
          FETCH: begin
            if (icache_ack_i) begin
              fetch_addr <= addr_inc;
              misalign_o <= 1'b0;
              if (count_next == DEPTH_C) begin
                state        <= FULL;
                icache_req_o <= 1'b0;
              end else begin
                icache_addr_o <= addr_inc;
              end
            end
          end
          FULL: begin
            if (count_next != DEPTH_C) begin
              state         <= FETCH;
              icache_req_o  <= 1'b1;
              icache_addr_o <= fetch_addr;
            end
          end
          DROP: begin
            if (icache_ack_i) begin
              state         <= FETCH;
              icache_addr_o <= fetch_addr;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: directed scenarios followed by random traffic,
// all checked against a transaction-level model of the fetch stream and buffer occupancy.
module tb_fetch_ctrl;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h8000_0000;
  localparam int          CW       = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          reset;
  logic          redirect_i;
  logic [31:0]   redirect_pc_i;
  logic          pop_i;
  logic          icache_req_o;
  logic [31:0]   icache_addr_o;
  logic          icache_ack_i;
  logic [31:0]   icache_instr_i;
  logic          buf_push_o;
  logic [31:0]   buf_wdata_o;
  logic [31:0]   buf_pc_o;
  logic          buf_flush_o;
  logic          misalign_o;
  logic [CW-1:0] count_o;

  fetch_ctrl #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i), .pop_i(pop_i),
    .icache_req_o(icache_req_o), .icache_addr_o(icache_addr_o),
    .icache_ack_i(icache_ack_i), .icache_instr_i(icache_instr_i),
    .buf_push_o(buf_push_o), .buf_wdata_o(buf_wdata_o), .buf_pc_o(buf_pc_o),
    .buf_flush_o(buf_flush_o), .misalign_o(misalign_o), .count_o(count_o)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference state: expected next stream PC, occupancy, misalign flag, and the cache's view.
  logic [31:0] model_pc;
  int          model_count;
  bit          model_mis;
  bit          outstanding;
  bit          stale;
  logic [31:0] out_addr;
  int          remaining;
  int          lat;
  int          stall;
  bit          redir_on_ack;
  bit          pop_on_ack;
  bit          did_redir;
  bit          last_push;
  logic [31:0] pushq[$];

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return (a * 32'h9E37_79B9) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    model_pc    = RESET_PC;
    model_count = 0;
    model_mis   = 1'b0;
    outstanding = 1'b0;
    stale       = 1'b0;
    stall       = 0;
  endtask

  // One clock cycle: entered and left at posedge+1.
  task automatic step(input bit redir, input logic [31:0] rpc, input bit pop);
    bit ack;
    bit push_exp;
    int c0;
    if (icache_req_o && !outstanding) begin
      check("req_addr", icache_addr_o, model_pc);
      outstanding = 1'b1;
      out_addr    = icache_addr_o;
      remaining   = lat;
    end else if (outstanding) begin
      check("req_hold", {icache_req_o, icache_addr_o}, {1'b1, out_addr});
    end
    ack = outstanding && (remaining == 0);
    if (redir_on_ack) redir = ack;
    if (pop_on_ack)   pop   = ack;
    did_redir      = redir;
    redirect_i     = redir;
    redirect_pc_i  = rpc;
    pop_i          = pop;
    icache_ack_i   = ack;
    icache_instr_i = ack ? word_of(out_addr) : $urandom();
    push_exp       = ack && !redir && !stale;
    #3;
    check("flush", buf_flush_o, redir);
    check("push", buf_push_o, push_exp);
    if (push_exp) begin
      check("push_pc", buf_pc_o, model_pc);
      check("push_data", buf_wdata_o, word_of(model_pc));
    end
    check("count", count_o, model_count);
    check("misalign", misalign_o, model_mis);
    if (model_count == DEPTH && !outstanding) check("full_noreq", icache_req_o, 0);
    if (!icache_req_o && model_count < DEPTH) stall++;
    else stall = 0;
    check("stall_bound", stall <= 2, 1);
    last_push = buf_push_o;
    if (buf_push_o) pushq.push_back(buf_pc_o);
    @(posedge clk);
    c0 = model_count;
    if (redir) begin
      stale       = outstanding && !ack;
      model_pc    = {rpc[31:2], 2'b00};
      model_mis   = rpc[1];
      model_count = 0;
    end else begin
      model_count = c0 + (push_exp ? 1 : 0) - ((pop && c0 != 0) ? 1 : 0);
      if (push_exp) begin
        model_pc  = model_pc + 32'd4;
        model_mis = 1'b0;
      end
    end
    if (ack) begin
      outstanding = 1'b0;
      stale       = 1'b0;
    end else if (outstanding) begin
      remaining--;
    end
    #1;
    redirect_i   = 1'b0;
    pop_i        = 1'b0;
    icache_ack_i = 1'b0;
  endtask

  task automatic run_until_push(input string tag);
    bit got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      step(1'b0, 32'h0, 1'b0);
      got = last_push;
    end
    check(tag, got, 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req"},   icache_req_o, 0);
    check({tag, "_addr"},  icache_addr_o, 0);
    check({tag, "_push"},  buf_push_o, 0);
    check({tag, "_flush"}, buf_flush_o, 0);
    check({tag, "_count"}, count_o, 0);
    check({tag, "_mis"},   misalign_o, 0);
  endtask

  initial begin
    bit got;
    redir_on_ack  = 1'b0;
    pop_on_ack    = 1'b0;
    lat           = 1;
    reset         = 1'b0;
    redirect_i    = 1'b1;
    redirect_pc_i = 32'h1234_5672;
    pop_i         = 1'b1;
    icache_ack_i  = 1'b1;
    icache_instr_i = 32'hDEAD_BEEF;
    model_reset();
    #2;
    check_reset_outputs("rst");
    redirect_i   = 1'b0;
    pop_i        = 1'b0;
    icache_ack_i = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;

    // Fill from reset with a one-cycle cache and no consumer.
    check("idle_first_cycle", icache_req_o, 0);
    pushq.delete();
    repeat (12) step(1'b0, 32'h0, 1'b0);
    check("fill_count", count_o, DEPTH);
    check("fill_noreq", icache_req_o, 0);
    check("fill_n", pushq.size(), 4);
    if (pushq.size() == 4)
      check("fill_pcs", {pushq[0], pushq[1], pushq[2], pushq[3]},
            {32'h8000_0000, 32'h8000_0004, 32'h8000_0008, 32'h8000_000C});

    // One pop from FULL restarts fetch at the next sequential word.
    step(1'b0, 32'h0, 1'b1);
    check("pop_count", count_o, 3);
    check("resume_req", {icache_req_o, icache_addr_o}, {1'b1, 32'h8000_0010});
    run_until_push("resume_push");
    check("refill_count", count_o, 4);

    // Redirect while a slow request is pending: stale ack is dropped.
    step(1'b1, 32'h8000_0000, 1'b0);
    lat = 1;
    run_until_push("pre_push0");
    run_until_push("pre_push1");
    lat = 3;
    step(1'b0, 32'h0, 1'b0);
    check("slow_req_addr", icache_addr_o, 32'h8000_0008);
    step(1'b1, 32'h8000_1002, 1'b0);
    check("drop_count", count_o, 0);
    check("drop_mis", misalign_o, 1);
    check("drop_hold", {icache_req_o, icache_addr_o}, {1'b1, 32'h8000_0008});
    pushq.delete();
    repeat (2) step(1'b0, 32'h0, 1'b0);
    check("stale_nopush", pushq.size(), 0);
    lat = 1;
    run_until_push("redir_push");
    if (pushq.size() > 0) check("redir_pc", pushq[0], 32'h8000_1000);
    check("mis_cleared", misalign_o, 0);

    // Redirect in the same cycle as an ack.
    lat = 2;
    redir_on_ack = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      step(1'b0, 32'h0000_2000, 1'b0);
      got = did_redir;
    end
    redir_on_ack = 1'b0;
    check("ackredir_seen", got, 1);
    check("ackredir_nopush", last_push, 0);
    check("ackredir_req", {icache_req_o, icache_addr_o}, {1'b1, 32'h0000_2000});

    // Push and pop together, then pop on an empty buffer.
    lat = 1;
    run_until_push("pp_push0");
    run_until_push("pp_push1");
    check("pp_pre_count", count_o, 2);
    pop_on_ack = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      step(1'b0, 32'h0, 1'b0);
      got = last_push;
    end
    pop_on_ack = 1'b0;
    check("pp_seen", got, 1);
    check("pp_count", count_o, 2);
    step(1'b1, 32'h0000_3000, 1'b1);
    check("redir_pop_count", count_o, 0);
    lat = 5;
    step(1'b0, 32'h0, 1'b1);
    check("empty_pop_count", count_o, 0);

    // Address wrap at the top of the address space.
    step(1'b1, 32'hFFFF_FFFC, 1'b0);
    lat = 1;
    pushq.delete();
    run_until_push("wrap_push0");
    run_until_push("wrap_push1");
    check("wrap_n", pushq.size(), 2);
    if (pushq.size() == 2) check("wrap_pcs", {pushq[0], pushq[1]}, {32'hFFFF_FFFC, 32'h0000_0000});

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      logic [31:0] rpc;
      rpc    = $urandom();
      rpc[0] = 1'b0;
      lat    = $urandom_range(1, 3);
      step(($urandom_range(0, 99) < 5), rpc, ($urandom_range(0, 99) < 40));
    end

    // Reset asserted while a request is outstanding.
    lat = 3;
    step(1'b1, 32'h0000_4000, 1'b0);
    step(1'b0, 32'h0, 1'b0);
    check("mid_req_live", icache_req_o, 1);
    reset        = 1'b0;
    icache_ack_i = 1'b1;
    redirect_i   = 1'b1;
    #2;
    check_reset_outputs("midrst");
    @(posedge clk);
    #1;
    icache_ack_i = 1'b0;
    redirect_i   = 1'b0;
    reset        = 1'b1;
    model_reset();
    check("post_rst_idle", icache_req_o, 0);
    lat = 1;
    pushq.delete();
    run_until_push("post_rst_push");
    if (pushq.size() > 0) check("post_rst_pc", pushq[0], RESET_PC);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
